// File: rtl/fulladder_seq_ctrl.sv
// Multi-cycle ripple adder: adds one WIDTH-bit chunk per cycle, LSB chunk first,
// and presents the registered sum/carry-out until the consumer takes it.
`timescale 1ns/1ps

module fulladder_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   cout,
  output logic                   busy,
  output logic [1:0]             fsm_state
);

  localparam int TW = WIDTH * WORDS;
  // One spare bit so k can reach WORDS after the last chunk without wrapping.
  localparam int CW = $clog2(WORDS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [TW-1:0]   a_reg;
  logic [TW-1:0]   b_reg;
  logic            carry_reg;
  logic [CW-1:0]   k;
  logic [WIDTH-1:0] a_chunk;
  logic [WIDTH-1:0] b_chunk;
  logic [WIDTH:0]  chunk_sum;
  logic            last;

  // Handshake: a transfer happens on the rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = ADD;
      ADD:     if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    fsm_state = state;
  end

  // Chunk select with constant slices keeps the mux plain and width-clean.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k == CW'(i)) begin
        a_chunk = a_reg[i*WIDTH +: WIDTH];
        b_chunk = b_reg[i*WIDTH +: WIDTH];
      end
    end
  end

  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{WIDTH{1'b0}}, carry_reg};
  assign last      = (k == CW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      k         <= '0;
      s         <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            k         <= '0;
            s         <= '0;
          end
        end
        ADD: begin
          carry_reg <= chunk_sum[WIDTH];
          k         <= k + 1'b1;
          for (int i = 0; i < WORDS; i++) begin
            if (k == CW'(i)) begin
              s[i*WIDTH +: WIDTH] <= chunk_sum[WIDTH-1:0];
            end
          end
          if (last) begin
            cout <= chunk_sum[WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fulladder_seq_ctrl.sv
// Directed bench for fulladder_seq_ctrl: WIDTH=8/WORDS=4 main instance plus a
// WORDS=1 instance for the single-chunk corner.
`timescale 1ns/1ps

module tb_fulladder_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        cout;
  logic        busy;
  logic [1:0]  fsm_state;

  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        cin1;
  logic        out_valid1;
  logic        out_ready1;
  logic [7:0]  s1;
  logic        cout1;
  logic        busy1;
  logic [1:0]  fsm_state1;

  int n_vec;
  int n_err;
  logic [32:0] exp_q[$];

  fulladder_seq_ctrl #(.WIDTH(8), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .busy(busy), .fsm_state(fsm_state)
  );

  fulladder_seq_ctrl #(.WIDTH(8), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .cout(cout1), .busy(busy1), .fsm_state(fsm_state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns edges from accept to out_valid.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        output int lat);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; cin = ~cv;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int cyc;
    int sent;
    int last_acc;
    logic [32:0] got;
    logic [31:0] va[3];
    logic [31:0] vb[3];
    logic        vc[3];
    logic [32:0] ve[3];

    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;

    // reset state
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_state", fsm_state, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // full carry ripple
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("ripple_lat", lat, 4);
    check("ripple_s", s, 32'h0000_0000);
    check("ripple_cout", cout, 1);
    check("done_in_ready", in_ready, 0);
    check("done_busy", busy, 1);
    @(posedge clk); #1;
    check("idle_after_done", in_ready, 1);
    check("idle_hold_s", s, 32'h0000_0000);
    check("idle_hold_cout", cout, 1);

    // mixed operands with carry-in, inputs scrambled after accept
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, lat);
    check("mix_lat", lat, 4);
    check("mix_s", s, 32'h2345_678A);
    check("mix_cout", cout, 0);
    @(posedge clk); #1;

    // backpressure in DONE with in_valid and operand churn
    out_ready = 1'b0;
    run_op(32'hF000_0000, 32'h2000_0005, 1'b0, lat);
    check("bp_lat", lat, 4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      b = (i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("bp_s", s, 32'h1000_0005);
      check("bp_cout", cout, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // reset in the 2nd ADD cycle
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_s", s, 0);
    check("abort_cout", cout, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(32'h1, 32'h1, 1'b0, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_s", s, 32'h0000_0002);
    check("post_rst_cout", cout, 0);
    @(posedge clk); #1;

    // back-to-back with in_valid and out_ready held high
    va[0] = 32'h0000_FFFF; vb[0] = 32'h0000_0001; vc[0] = 1'b0; ve[0] = 33'h0_0001_0000;
    va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vc[1] = 1'b1; ve[1] = 33'h1_0000_0001;
    va[2] = 32'hAAAA_AAAA; vb[2] = 32'h5555_5555; vc[2] = 1'b1; ve[2] = 33'h1_0000_0000;
    in_valid = 1'b1; out_ready = 1'b1;
    sent = 0; last_acc = -1; cyc = 0;
    while (cyc < 40) begin
      if (out_valid) begin
        got = {cout, s};
        if (exp_q.size() > 0) check("b2b_result", got, exp_q.pop_front());
        else check("b2b_unexpected", got, 33'h0);
      end
      if (in_ready) begin
        if (sent == 3) break;
        if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 6);
        last_acc = cyc;
        a = va[sent]; b = vb[sent]; cin = vc[sent];
        exp_q.push_back(ve[sent]);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_timeout", (cyc < 40), 1);
    check("b2b_drained", exp_q.size(), 0);

    // single-chunk instance
    a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w1_lat", lat, 1);
    check("w1_s", s1, 8'h01);
    check("w1_cout", cout1, 1);
    @(posedge clk); #1;
    check("w1_idle", in_ready1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fulladder_seq_ctrl.md
FULLADDER_SEQ_CTRL -- requirements
Module: fulladder_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the adder chunk processed per cycle.
REQ-002 Parameter WORDS, default 4: number of chunks per operand; legal range WORDS >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH*WORDS  operand A.
REQ-008 b  input  WIDTH*WORDS  operand B.
REQ-009 cin  input  1  carry-in to chunk 0.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 s  output  WIDTH*WORDS  registered sum.
REQ-013 cout  output  1  registered carry-out of the most-significant chunk.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept: in IDLE with in_valid=1, the block SHALL latch a, b and cin into internal registers, clear the chunk counter and the sum register, and go to ADD.
REQ-018 In IDLE with in_valid=0, the block SHALL remain in IDLE and hold all registers.
REQ-019 Each ADD cycle SHALL compute {c, sum} = a_chunk[k] + b_chunk[k] + carry_reg (WIDTH+1-bit result).
REQ-020 On the same edge it SHALL write sum into s[k*WIDTH +: WIDTH], load c into carry_reg, and increment k.
REQ-021 carry_reg SHALL equal the latched cin at k=0.
REQ-022 When k = WORDS-1 the edge SHALL also load cout with c and move to DONE.
REQ-023 The counter SHALL be $clog2(WORDS)+1 bits wide, so WORDS=1 and powers of two do not overflow; k SHALL never wrap within an operation.
REQ-024 Latency: out_valid SHALL rise exactly WORDS clock edges after the accept edge.
REQ-025 Each operation SHALL occupy WORDS+2 cycles minimum (accept, WORDS ADD cycles, DONE handshake).
REQ-026 In DONE, s and cout SHALL be held stable until out_ready=1.
REQ-027 When out_ready=1 in DONE, the block SHALL return to IDLE on that edge.
REQ-028 s and cout SHALL keep their values in IDLE until the next accept.
REQ-029 Backpressure: in_valid during ADD or DONE SHALL be ignored, because in_ready=0 there; no operand is lost or latched.
REQ-030 Input isolation: changes on a, b or cin after the accept edge SHALL NOT affect the result.
REQ-031 The result SHALL equal (a + b + cin) mod 2^(WIDTH*WORDS), with cout as bit WIDTH*WORDS of the exact sum.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force the state to IDLE and clear the counter, carry_reg, s, cout, out_valid and busy to 0.
REQ-033 While rst_n=0, in_ready SHALL be 1, because in_ready is decoded from state IDLE.
REQ-034 Reset asserted in ADD or DONE SHALL abort the operation with no result presented.
REQ-035 The first rising edge after rst_n deasserts SHALL accept a request if in_valid=1.

Verification (WIDTH=8, WORDS=4)
REQ-036 Case a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1: out_valid SHALL rise 4 edges after accept, with s=0x00000000 and cout=1 (full carry ripple across chunks).
REQ-037 Case a=0x12345678, b=0x11111111, cin=1: the block SHALL produce s=0x2345678A and cout=0.
REQ-038 Case out_ready=0 for 10 cycles in DONE, while in_valid=1 and a/b toggle: s and cout SHALL stay constant and in_ready SHALL stay 0; after out_ready=1, the block SHALL be back in IDLE on the next edge.
REQ-039 Case rst_n pulsed low during the 2nd ADD cycle: s, cout, out_valid and busy SHALL read 0 immediately; in_ready SHALL be 1; a fresh 0x1+0x1 SHALL then yield s=0x00000002 and cout=0.
REQ-040 Case back-to-back requests with in_valid held 1 and out_ready held 1: accepts SHALL occur exactly every 6 cycles and each result SHALL match the reference sum.
REQ-041 Case WORDS=1, a=0xFF, b=0x01, cin=1: out_valid SHALL rise 1 edge after accept, with s=0x01 and cout=1.
